// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the MIPS back-end pipeline registers.
//
// Holds the datapath widths, the reset / exception-entry PC constants, the
// packed layouts of the M and W stage bundles, and the remaining-latency
// decrement helper used when an instruction advances from E into M.
package cpu_defs;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int EXC_W  = 5;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [WORD_W-1:0] EXC_PC   = 32'h0000_4180;
  localparam logic [EXC_W-1:0]  EXC_NONE = 5'd0;

  // pc is the first member, so it occupies the top WORD_W bits of the
  // packed bundle. The reset / clear constants in the top rely on that.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] store_data;
    logic [REG_W-1:0]  a3;
    logic [REG_W-1:0]  rt;
    logic              reg_write;
    logic [TNEW_W-1:0] tnew;
    logic [EXC_W-1:0]  exc_code;
    logic              bd;
  } m_bundle_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_rd;
    logic [REG_W-1:0]  a3;
    logic              reg_write;
  } w_bundle_t;

  // One stage of latency is consumed per boundary; stop at zero instead of
  // wrapping, so a ready result never looks like a three-cycle producer.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    if (t == '0) begin
      return '0;
    end
    return t - 1'b1;
  endfunction

endpackage

// File: rtl/mw_pipe_regs_stage_reg.sv
// Generic pipeline-stage register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, loads RST_VAL
//   clr    synchronous clear (bubble insertion), loads CLR_VAL
//   hold   keep the current contents (stall)
//   d      next-stage value captured on a normal advance
//   q      registered stage contents
//
// Priority per edge: rst_n low > clr > hold > load d.
module stage_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = d;
    if (!rst_n) begin
      data_d = RST_VAL;
    end else if (clr) begin
      data_d = CLR_VAL;
    end else if (hold) begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/mw_pipe_regs.sv
// E->M and M->W pipeline register bank of the 5-stage MIPS core.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   Req             exception/interrupt request: both stages become bubbles
//                   whose PC is the handler entry
//   Freeze          hold both stages (bus wait); loses to Req and reset
//   E_*             fields produced by the E stage
//   M_MemRD         load data already extended, captured into W
//   M_*             registered M-stage fields
//   W_*             registered W-stage fields
//
// Every output comes straight from a flop; no input reaches an output
// combinationally. A3 and Tnew are normalised before entering M so that a
// non-writing instruction can never be matched by the forwarding unit.
module mw_pipe_regs
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] EXC_PC   = cpu_defs::EXC_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        Freeze,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_ALUResult,
  input  logic [31:0] E_StoreData,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  E_Rt,
  input  logic        E_RegWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  input  logic [31:0] M_MemRD,
  output logic [31:0] M_PC,
  output logic [31:0] M_Instr,
  output logic [31:0] M_ALUResult,
  output logic [31:0] M_StoreData,
  output logic [4:0]  M_A3,
  output logic [4:0]  M_Rt,
  output logic        M_RegWrite,
  output logic [1:0]  M_Tnew,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD,
  output logic [31:0] W_PC,
  output logic [31:0] W_Instr,
  output logic [31:0] W_ALUResult,
  output logic [31:0] W_MemRD,
  output logic [4:0]  W_A3,
  output logic        W_RegWrite
);

  localparam int M_W = $bits(m_bundle_t);
  localparam int W_W = $bits(w_bundle_t);

  // Reset and flush values: only the PC (top bits) is non-zero.
  localparam logic [M_W-1:0] M_RST_VAL = {RESET_PC, {(M_W-WORD_W){1'b0}}};
  localparam logic [M_W-1:0] M_CLR_VAL = {EXC_PC,   {(M_W-WORD_W){1'b0}}};
  localparam logic [W_W-1:0] W_RST_VAL = {RESET_PC, {(W_W-WORD_W){1'b0}}};
  localparam logic [W_W-1:0] W_CLR_VAL = {EXC_PC,   {(W_W-WORD_W){1'b0}}};

  m_bundle_t m_d;
  m_bundle_t m_q;
  w_bundle_t w_d;
  w_bundle_t w_q;

  // E -> M: capture E fields, normalising A3/Tnew for non-writers
  always_comb begin
    m_d            = '0;
    m_d.pc         = E_PC;
    m_d.instr      = E_Instr;
    m_d.alu_result = E_ALUResult;
    m_d.store_data = E_StoreData;
    m_d.rt         = E_Rt;
    m_d.reg_write  = E_RegWrite;
    m_d.exc_code   = E_ExcCode;
    m_d.bd         = E_BD;
    if (E_RegWrite) begin
      m_d.a3   = E_A3;
      m_d.tnew = tnew_dec(E_Tnew);
    end else begin
      m_d.a3   = '0;
      m_d.tnew = '0;
    end
  end

  stage_reg #(
    .W       (M_W),
    .RST_VAL (M_RST_VAL),
    .CLR_VAL (M_CLR_VAL)
  ) u_m_stage (
    .clk   (clk),
    .rst_n (reset),
    .clr   (Req),
    .hold  (Freeze),
    .d     (m_d),
    .q     (m_q)
  );

  // M -> W: W inherits the already-normalised A3 and carries no Tnew
  always_comb begin
    w_d            = '0;
    w_d.pc         = m_q.pc;
    w_d.instr      = m_q.instr;
    w_d.alu_result = m_q.alu_result;
    w_d.mem_rd     = M_MemRD;
    w_d.a3         = m_q.a3;
    w_d.reg_write  = m_q.reg_write;
  end

  stage_reg #(
    .W       (W_W),
    .RST_VAL (W_RST_VAL),
    .CLR_VAL (W_CLR_VAL)
  ) u_w_stage (
    .clk   (clk),
    .rst_n (reset),
    .clr   (Req),
    .hold  (Freeze),
    .d     (w_d),
    .q     (w_q)
  );

  assign M_PC        = m_q.pc;
  assign M_Instr     = m_q.instr;
  assign M_ALUResult = m_q.alu_result;
  assign M_StoreData = m_q.store_data;
  assign M_A3        = m_q.a3;
  assign M_Rt        = m_q.rt;
  assign M_RegWrite  = m_q.reg_write;
  assign M_Tnew      = m_q.tnew;
  assign M_ExcCode   = m_q.exc_code;
  assign M_BD        = m_q.bd;

  assign W_PC        = w_q.pc;
  assign W_Instr     = w_q.instr;
  assign W_ALUResult = w_q.alu_result;
  assign W_MemRD     = w_q.mem_rd;
  assign W_A3        = w_q.a3;
  assign W_RegWrite  = w_q.reg_write;

endmodule

// File: doc/mw_pipe_regs.md
Name: mw_pipe_regs

Overview:
- Pipeline register bank for the E→M and M→W boundaries of the 5-stage MIPS core.
- Registers the destination-register and timing fields produced in E: M_A3, M_Rt, M_RegWrite, M_Tnew, then W_A3 and W_RegWrite. The hazard forwarding unit consumes these directly, together with the data fields carried by the M and W stages.
- Handles the remaining-latency (Tnew) countdown, bubble insertion on exception/interrupt request, and whole-back-end freeze.

Parameters:
- RESET_PC, 32'h0000_3000, PC value held by both stages after reset.
- EXC_PC, 32'h0000_4180, PC loaded into the M stage on Req, so the macro PC points at the handler entry.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 at a rising edge clears both stages.
- Req  in  1  exception/interrupt request; flushes both stages this edge.
- Freeze  in  1  holds both stages unchanged (bus wait).
- E_PC  in  32  PC of instruction in E.
- E_Instr  in  32  instruction word in E.
- E_ALUResult  in  32  ALU/MDU result from E.
- E_StoreData  in  32  forwarded rt value for stores.
- E_A3  in  5  destination register in E.
- E_Rt  in  5  rt field in E.
- E_RegWrite  in  1  E instruction writes the GRF.
- E_Tnew  in  2  cycles until E result is available.
- E_ExcCode  in  5  exception code accumulated up to E.
- E_BD  in  1  E instruction is in a delay slot.
- M_MemRD  in  32  load data (already extended) from the DM/bridge in M.
- M_PC, M_Instr, M_ALUResult, M_StoreData  out  32 each  M-stage copies.
- M_A3, M_Rt  out  5 each  M-stage register fields.
- M_RegWrite  out  1  M-stage write enable.
- M_Tnew  out  2  remaining latency in M.
- M_ExcCode  out  5  M-stage exception code.
- M_BD  out  1  M-stage delay-slot flag.
- W_PC, W_Instr, W_ALUResult, W_MemRD  out  32 each  W-stage copies.
- W_A3  out  5  W-stage destination register.
- W_RegWrite  out  1  W-stage write enable.

Behaviour:
- Priority per edge: reset==0 > Req > Freeze > normal advance.
- Reset:
  - All outputs become 0, except M_PC = W_PC = RESET_PC.
  - A reset arriving mid-stream discards in-flight instructions; there is no partial state.
- Normal advance (one-cycle latency per stage):
  - Every M_* field takes its E_* input.
  - W_PC, W_Instr, W_ALUResult, W_A3, W_RegWrite take the current M values.
  - W_MemRD takes M_MemRD.
- Tnew countdown: M_Tnew <= (E_Tnew == 0) ? 0 : E_Tnew − 1. It saturates at 0 and never wraps to 3. W carries no Tnew; its value is implicitly 0.
- A3 normalisation: when E_RegWrite == 0, M_A3 is captured as 0, so the forwarding unit never matches a non-writing instruction. W_A3 inherits the normalised value.
- Req flush:
  - M becomes a bubble: Instr, ALUResult, StoreData, A3, Rt, RegWrite, Tnew, ExcCode, BD all 0, and M_PC = EXC_PC.
  - W becomes a bubble: all fields 0, W_PC = EXC_PC.
  - Req takes effect even while Freeze = 1.
- Freeze: every register holds its value. M_MemRD is not sampled.
- Bubble invariant: a stage with RegWrite == 0 always has A3 == 0 and Tnew == 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_defs holds:
  - widths: WORD_W = 32, REG_W = 5, TNEW_W = 2, EXC_W = 5
  - constants: RESET_PC, EXC_PC, EXC_NONE = 5'd0
- One natural sub-module, stage_reg: a parameterised-width register with clear value, clear enable and hold enable. It is instantiated twice, once for the M bundle and once for the W bundle. Tnew decrement and A3 normalisation sit in mw_pipe_regs ahead of the M instance.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release.
  - Required: M_PC = W_PC = 32'h3000.
  - Required: M_RegWrite = W_RegWrite = 0, M_A3 = W_A3 = 0, M_Tnew = 0.
- Pipeline flow: E_PC=3004, E_A3=8, E_RegWrite=1, E_Tnew=2, E_ALUResult=0x1234.
  - Required after edge 1: M_A3=8, M_Tnew=1, M_ALUResult=0x1234.
  - Required after edge 2: W_A3=8, W_RegWrite=1, W_PC=3004.
- Tnew saturation and normalisation:
  - E_Tnew=0 → M_Tnew=0.
  - E_Tnew=3 → M_Tnew=2.
  - E_RegWrite=0 with E_A3=31 → M_A3=0.
- Req flush: load M and W with valid instructions, then pulse Req for 1 cycle.
  - Required: M_PC = W_PC = 32'h4180; all RegWrite, A3, Tnew, Instr = 0.
  - Required: normal flow resumes on the next edge.
- Freeze: hold Freeze=1 for 3 cycles while E inputs change every cycle.
  - Required: M and W outputs stay constant.
  - Required: on release, M takes the current E inputs.
- Simultaneous events:
  - Freeze=1 with Req=1 → flush occurs.
  - reset=0 with Req=1 → M_PC = 32'h3000, not 4180.
